// File: rtl/isa_pkg.sv
// Shared ISA constants: I-type opcode encodings and the opcode field position.
package isa_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OPC_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_XORI  = 6'b001110;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;

  // Pull the opcode field out of an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] inst);
    return inst[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/imm_ext.sv
// Immediate extender: sign- and zero-extends a 16-bit immediate to 32 bits.
module imm_ext (
  input  logic        [15:0] imm,
  output logic signed [31:0] simm,
  output logic        [31:0] zimm
);

  assign simm = {{16{imm[15]}}, imm};
  assign zimm = {16'b0, imm};

endmodule

// File: rtl/i_alu.sv
// I-type ALU: decodes the opcode, combines rs with the extended immediate,
// and registers the result with one cycle of latency.
module i_alu
  import isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_reg,
  input  logic [31:0] ALU_I1,
  input  logic [15:0] ALU_I2,
  output logic [31:0] ALU_out
);

  logic        [OPC_W-1:0] opcode;
  logic signed [31:0]      rs_s;
  logic signed [31:0]      simm;
  logic        [31:0]      zimm;
  logic        [31:0]      result_p0;
  logic        [31:0]      alu_out_p1;
  logic                    unused_inst_bits;

  assign opcode = opcode_of(inst_reg);
  assign rs_s   = ALU_I1;

  // Only the opcode field is decoded; the remaining instruction bits are don't-care.
  assign unused_inst_bits = ^inst_reg[OPC_LSB-1:0];

  imm_ext u_imm_ext (
    .imm  (ALU_I2),
    .simm (simm),
    .zimm (zimm)
  );

  // Set-less-than results are a single flag zero-extended to the word width.
  function automatic logic [31:0] flag32(input logic f);
    return {31'b0, f};
  endfunction

  // Stage p0: combinational opcode decode; unknown opcodes produce zero.
  always_comb begin
    result_p0 = '0;
    case (opcode)
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: result_p0 = ALU_I1 + simm;
      OP_SLTI:  result_p0 = flag32(rs_s < simm);
      OP_SLTIU: result_p0 = flag32(ALU_I1 < $unsigned(simm));
      OP_ANDI:  result_p0 = ALU_I1 & zimm;
      OP_ORI:   result_p0 = ALU_I1 | zimm;
      OP_XORI:  result_p0 = ALU_I1 ^ zimm;
      OP_LUI:   result_p0 = {ALU_I2, 16'b0};
      default:  result_p0 = '0;
    endcase
  end

  // Stage p1: output register; reset clears it and drops the in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) alu_out_p1 <= '0;
    else        alu_out_p1 <= result_p0;
  end

  assign ALU_out = alu_out_p1;

endmodule

// File: tb/tb_i_alu.sv
// Table-driven directed bench for the I-type ALU.
module tb_i_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_reg;
  logic [31:0] ALU_I1;
  logic [15:0] ALU_I2;
  logic [31:0] ALU_out;

  int total;
  int bad;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] i1;
    logic [15:0] i2;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  i_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inst_reg (inst_reg),
    .ALU_I1   (ALU_I1),
    .ALU_I2   (ALU_I2),
    .ALU_out  (ALU_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%08h want=%08h", name, got, want);
    end
  endtask

  // Present inputs just after an edge; low instruction bits are randomised.
  task automatic drive(input logic [5:0] op, input logic [31:0] i1, input logic [15:0] i2);
    inst_reg = {op, 26'($urandom)};
    ALU_I1   = i1;
    ALU_I2   = i2;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{6'b001000, 32'h00000001, 16'h0002, 32'h00000003}; // addi
    vecs[1]  = '{6'b001000, 32'h00000000, 16'hFFFF, 32'hFFFFFFFF}; // addi -1
    vecs[2]  = '{6'b001010, 32'h00000002, 16'h0001, 32'h00000000}; // slti 2<1
    vecs[3]  = '{6'b001010, 32'hFFFFFFFE, 16'h0001, 32'h00000001}; // slti -2<1
    vecs[4]  = '{6'b001011, 32'hFFFFFFFE, 16'h0001, 32'h00000000}; // sltiu
    vecs[5]  = '{6'b001010, 32'h00000005, 16'h0005, 32'h00000000}; // slti equal
    vecs[6]  = '{6'b001011, 32'h00000005, 16'hFFFF, 32'h00000001}; // sltiu vs FFFFFFFF
    vecs[7]  = '{6'b001011, 32'hFFFFFFFF, 16'hFFFF, 32'h00000000}; // sltiu equal max
    vecs[8]  = '{6'b001100, 32'hF0F0F0F0, 16'hFF00, 32'h0000F000}; // andi
    vecs[9]  = '{6'b001101, 32'hF0F0F0F0, 16'hFF00, 32'hF0F0FFF0}; // ori
    vecs[10] = '{6'b001110, 32'hF0F0F0F0, 16'hFF00, 32'hF0F00FF0}; // xori
    vecs[11] = '{6'b001110, 32'h00000000, 16'h8000, 32'h00008000}; // xori zero-ext
    vecs[12] = '{6'b001111, 32'hDEADBEEF, 16'h1234, 32'h12340000}; // lui
    vecs[13] = '{6'b100011, 32'h00000100, 16'hFFFC, 32'h000000FC}; // lw
    vecs[14] = '{6'b101011, 32'h00000100, 16'h0008, 32'h00000108}; // sw
    vecs[15] = '{6'b001000, 32'h7FFFFFFF, 16'h0001, 32'h80000000}; // addi wrap
    vecs[16] = '{6'b001001, 32'h7FFFFFFF, 16'h0001, 32'h80000000}; // addiu wrap
    vecs[17] = '{6'b000000, 32'h00000005, 16'h0005, 32'h00000000}; // undefined
    vecs[18] = '{6'b111111, 32'hFFFFFFFF, 16'hFFFF, 32'h00000000}; // undefined
    vecs[19] = '{6'b001010, 32'h00000000, 16'hFFFF, 32'h00000000}; // slti 0<-1
    vecs[20] = '{6'b001010, 32'hFFFFFFF0, 16'hFFFF, 32'h00000001}; // slti -16<-1
    vecs[21] = '{6'b001101, 32'h12340000, 16'h8001, 32'h12348001}; // ori zero-ext

    // Reset held two edges with addi 5+5 presented
    rst_n = 1'b0;
    drive(6'b001000, 32'd5, 16'd5);
    step;
    check("reset_edge1", ALU_out, 32'h0);
    step;
    check("reset_edge2", ALU_out, 32'h0);
    rst_n = 1'b1;
    step;
    check("first_after_reset", ALU_out, 32'd10);

    // Table, applied back-to-back: each result one edge after its inputs
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].i1, vecs[i].i2);
      step;
      check($sformatf("vec%0d", i), ALU_out, vecs[i].exp);
    end

    // Output holds between edges
    drive(6'b001000, 32'd40, 16'd2);
    step;
    drive(6'b001111, 32'd0, 16'hABCD);
    #3;
    check("hold_between_edges", ALU_out, 32'd42);
    step;
    check("next_edge", ALU_out, 32'hABCD0000);

    // Mid-stream reset discards the in-flight result, then recovers
    drive(6'b001000, 32'd100, 16'd1);
    rst_n = 1'b0;
    step;
    check("midstream_reset", ALU_out, 32'h0);
    rst_n = 1'b1;
    drive(6'b001001, 32'd100, 16'hFFFF);
    step;
    check("recover_after_reset", ALU_out, 32'd99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
